// File: rtl/psram_hs_emulator.sv
// Block-RAM-backed stand-in for the PSRAM HS user interface: fixed-length bursts,
// fixed read latency, enforced inter-command gap and a timed calibration phase.
module psram_hs_emulator #(
  parameter int MEM_AW   = 6,
  parameter int BURST    = 4,
  parameter int RD_LAT   = 6,   // >= 2
  parameter int CMD_GAP  = 14,  // 1..255
  parameter int INIT_CYC = 64   // >= 2
) (
  input  logic        ext_clk,
  input  logic        rst_n,
  input  logic        cmd,
  input  logic        cmd_en,
  input  logic [20:0] addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  data_mask,
  output logic [63:0] rd_data,
  output logic        rd_data_valid,
  output logic        init_calib,
  output logic        busy,
  output logic        cmd_err
);

  localparam int BW    = $clog2(BURST + 1);
  localparam int IW    = $clog2(INIT_CYC);
  localparam int DEPTH = 2 ** MEM_AW;

  localparam logic [BW-1:0] BEATS_ALL  = BW'(BURST);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST - 1);
  localparam logic [7:0]    LAT_ISSUE  = 8'(RD_LAT - 2);
  localparam logic [7:0]    GAP_LAST   = 8'(CMD_GAP - 1);
  localparam logic [IW-1:0] CALIB_LAST = IW'(INIT_CYC - 1);

  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    GAP
  } state_t;

  state_t              state_reg;
  logic [MEM_AW-1:0]   base_reg;
  logic [BW-1:0]       beat_cnt_reg;
  logic [7:0]          lat_cnt_reg;
  logic [7:0]          gap_cnt_reg;
  logic [IW-1:0]       calib_cnt_reg;
  logic                rd_pend_reg;
  logic [63:0]         ram_q_reg;

  logic [63:0]         mem [0:DEPTH-1];

  logic [MEM_AW-1:0]   beat_addr;
  logic                wr_en;
  logic [MEM_AW-1:0]   wr_addr;
  logic [7:0]          byte_we;
  logic                rd_en;
  logic [MEM_AW-1:0]   rd_addr;

  // Only the low MEM_AW address bits select a word; the rest are don't-care.
  logic unused_addr;
  assign unused_addr = ^addr[20:MEM_AW];

  assign beat_addr = base_reg + MEM_AW'(beat_cnt_reg);

  // Beat 0 is written in the accepting cycle straight from the input address.
  assign wr_en   = (state_reg == IDLE && cmd_en && cmd) || (state_reg == WR_BURST);
  assign wr_addr = (state_reg == IDLE) ? addr[MEM_AW-1:0] : beat_addr;

  assign rd_en   = (state_reg == RD_WAIT && lat_cnt_reg == LAT_ISSUE) ||
                   (state_reg == RD_BURST && beat_cnt_reg != BEATS_ALL);
  assign rd_addr = (state_reg == RD_WAIT) ? base_reg : beat_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte_we
      assign byte_we[gi] = wr_en & ~data_mask[gi];
    end
  endgenerate

  always_ff @(posedge ext_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    if (rd_en) ram_q_reg <= mem[rd_addr];
  end

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= CALIB;
      base_reg      <= '0;
      beat_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      calib_cnt_reg <= '0;
      rd_pend_reg   <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      init_calib    <= 1'b0;
      busy          <= 1'b1;
      cmd_err       <= 1'b0;
    end else begin
      // RAM read issued last cycle becomes the presented beat this cycle.
      rd_pend_reg   <= rd_en;
      rd_data_valid <= rd_pend_reg;
      if (rd_pend_reg) rd_data <= ram_q_reg;

      if (cmd_en && state_reg != IDLE) cmd_err <= 1'b1;

      case (state_reg)
        CALIB: begin
          if (calib_cnt_reg == CALIB_LAST) begin
            state_reg  <= IDLE;
            init_calib <= 1'b1;
            busy       <= 1'b0;
          end else begin
            calib_cnt_reg <= calib_cnt_reg + IW'(1);
          end
        end
        IDLE: begin
          if (cmd_en) begin
            base_reg <= addr[MEM_AW-1:0];
            busy     <= 1'b1;
            if (cmd) begin
              beat_cnt_reg <= BW'(1);
              state_reg    <= (BURST == 1) ? GAP : WR_BURST;
              gap_cnt_reg  <= '0;
            end else begin
              lat_cnt_reg <= '0;
              state_reg   <= RD_WAIT;
            end
          end
        end
        WR_BURST: begin
          if (beat_cnt_reg == BEAT_LAST) begin
            beat_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            state_reg    <= GAP;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + BW'(1);
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == LAT_ISSUE) begin
            lat_cnt_reg  <= '0;
            beat_cnt_reg <= BW'(1);
            state_reg    <= RD_BURST;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 8'd1;
          end
        end
        RD_BURST: begin
          // Leaves on the cycle the final beat appears on rd_data.
          if (beat_cnt_reg == BEATS_ALL) begin
            beat_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            state_reg    <= GAP;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            busy        <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= CALIB;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_hs_emulator.sv
// Randomised bench for psram_hs_emulator: a word-array memory model plus cycle
// timing derived from the latency, burst and gap rules.
module tb_psram_hs_emulator;

  localparam int AW    = 6;
  localparam int B     = 4;
  localparam int L     = 6;
  localparam int G     = 14;
  localparam int IC    = 64;
  localparam int DEPTH = 2 ** AW;

  logic        ext_clk = 1'b0;
  logic        rst_n;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;
  logic        busy;
  logic        cmd_err;

  psram_hs_emulator #(
    .MEM_AW(AW), .BURST(B), .RD_LAT(L), .CMD_GAP(G), .INIT_CYC(IC)
  ) dut (
    .ext_clk(ext_clk), .rst_n(rst_n), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 ext_clk = ~ext_clk;

  logic [63:0] model [0:DEPTH-1];
  logic [63:0] wbeat [0:B-1];
  logic [7:0]  wmask [0:B-1];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_write(input int w, input logic [63:0] d, input logic [7:0] m);
    for (int k = 0; k < 8; k++)
      if (!m[k]) model[w % DEPTH][k*8 +: 8] = d[k*8 +: 8];
  endtask

  // Beats land on consecutive edges; next command allowed G cycles after the last beat.
  task automatic do_write(input logic [20:0] a);
    int w0;
    w0 = int'(a[AW-1:0]);
    @(negedge ext_clk);
    cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = wbeat[0]; data_mask = wmask[0];
    model_write(w0, wbeat[0], wmask[0]);
    for (int i = 1; i < B; i++) begin
      @(negedge ext_clk);
      cmd_en = 1'b0; addr = 21'($urandom); wr_data = wbeat[i]; data_mask = wmask[i];
      model_write(w0 + i, wbeat[i], wmask[i]);
    end
    @(negedge ext_clk);
    cmd_en = 1'b0; wr_data = {$urandom, $urandom}; data_mask = 8'h00;
    for (int g = 1; g <= G; g++) begin
      @(negedge ext_clk);
      if (g >= G - 1) check("wr_busy", busy, 64'(g < G));
    end
    $display("WR addr=%h b0=%h m0=%h", a, wbeat[0], wmask[0]);
  endtask

  task automatic do_read(input logic [20:0] a, input bit inj);
    int w0;
    bit exp_v;
    w0 = int'(a[AW-1:0]);
    @(negedge ext_clk);
    cmd_en = 1'b1; cmd = 1'b0; addr = a;
    @(negedge ext_clk);
    cmd_en = 1'b0;
    check("rd_valid_accept", rd_data_valid, 64'(0));
    for (int j = 1; j <= L + B - 1 + G; j++) begin
      @(negedge ext_clk);
      exp_v = (j >= L) && (j < L + B);
      check("rd_valid", rd_data_valid, 64'(exp_v));
      if (exp_v) check("rd_beat", rd_data, model[(w0 + j - L) % DEPTH]);
      if (j == L + B) check("rd_hold", rd_data, model[(w0 + B - 1) % DEPTH]);
      if (j >= L + B - 2 + G) check("rd_busy", busy, 64'(j < L + B - 1 + G));
      cmd_en = inj && (j == L + 1 || j == L + B + 3);
      cmd = 1'($urandom_range(0, 1));
      addr = 21'($urandom);
    end
    cmd_en = 1'b0;
    $display("RD addr=%h inj=%0d beat0=%h", a, inj, model[w0]);
  endtask

  // Expects rst_n low on entry; releases it and tracks the calibration count.
  task automatic init_seq(input bit inj);
    @(negedge ext_clk);
    rst_n = 1'b1;
    for (int j = 1; j <= IC + 2; j++) begin
      @(negedge ext_clk);
      check("init_calib", init_calib, 64'(j >= IC));
      check("init_busy", busy, 64'(j < IC));
      cmd_en = inj && (j == 10);
      cmd = 1'($urandom_range(0, 1));
    end
    cmd_en = 1'b0;
    check("calib_cmd_err", cmd_err, 64'(inj));
    $display("INIT inj=%0d done", inj);
  endtask

  task automatic rand_beats(input bit rand_mask);
    for (int i = 0; i < B; i++) begin
      wbeat[i] = {$urandom, $urandom};
      wmask[i] = rand_mask ? 8'($urandom) : 8'h00;
    end
  endtask

  initial begin
    cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 64'(0));
    check("rst_valid", rd_data_valid, 64'(0));
    check("rst_init", init_calib, 64'(0));
    check("rst_busy", busy, 64'(1));
    check("rst_cmd_err", cmd_err, 64'(0));
    repeat (3) @(negedge ext_clk);
    init_seq(1'b1);

    @(negedge ext_clk);
    rst_n = 1'b0;
    #1 check("rst2_cmd_err", cmd_err, 64'(0));
    repeat (2) @(negedge ext_clk);
    init_seq(1'b0);

    for (int b = 0; b < DEPTH; b += B) begin
      rand_beats(1'b0);
      do_write(21'(b) | (21'($urandom) << AW));
    end

    wbeat[0] = 64'h0123456789ABCDEF; wbeat[1] = 64'hDEADBEEF00000000;
    wbeat[2] = 64'd1;                wbeat[3] = 64'd2;
    for (int i = 0; i < B; i++) wmask[i] = 8'h00;
    do_write(21'h20);
    do_read(21'h20, 1'b0);

    rand_beats(1'b0);
    wbeat[0] = 64'h1111111111111111;
    do_write(21'h05);
    rand_beats(1'b0);
    wbeat[0] = 64'hFFFFFFFFFFFFFFFF; wmask[0] = 8'hF0;
    for (int i = 1; i < B; i++) wmask[i] = 8'hFF;
    do_write(21'h05);
    do_read(21'h05, 1'b0);

    rand_beats(1'b0);
    do_write(21'h0FE);
    do_read(21'h03E, 1'b0);

    repeat (24) begin
      if ($urandom_range(0, 1) == 1) begin
        rand_beats(1'b1);
        do_write(21'($urandom));
      end else begin
        do_read(21'($urandom), 1'b0);
      end
    end

    check("err_before", cmd_err, 64'(0));
    do_read(21'($urandom), 1'b1);
    check("err_set", cmd_err, 64'(1));
    do_read(21'($urandom), 1'b0);
    check("err_sticky", cmd_err, 64'(1));

    @(negedge ext_clk);
    cmd_en = 1'b1; cmd = 1'b0; addr = 21'h20;
    @(negedge ext_clk);
    cmd_en = 1'b0;
    repeat (L + 1) @(negedge ext_clk);
    check("mid_valid", rd_data_valid, 64'(1));
    check("mid_beat1", rd_data, model[8'h21]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rd_data_valid, 64'(0));
    check("mid_rst_init", init_calib, 64'(0));
    check("mid_rst_busy", busy, 64'(1));
    $display("RST during read beat 1");
    repeat (2) @(negedge ext_clk);
    init_seq(1'b0);
    do_read(21'h20, 1'b0);
    do_read(21'h03E, 1'b0);
    do_read(21'h05, 1'b0);
    do_read(21'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
